// File: rtl/clk_divider_prog.sv
// Multi-channel programmable clock divider. Each channel has a shadow
// half-period register that is applied only at the end of a full period.
module clk_divider_prog #(
  parameter int NUM_CH = 2,
  parameter int CNT_W = 24,
  parameter int SEL_W = 1,
  parameter logic [CNT_W-1:0] RST_HALF = CNT_W'(24'd10_000_000)
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              load,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] divided_clk,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] load_ack,
  output logic [NUM_CH-1:0] pending
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act;
    logic [CNT_W-1:0] shd;
    logic             pend;
    logic             dclk;
    logic             tck;
    logic             ack;
    logic             hit;
    logic             term;
    logic             apply;

    // An out-of-range ch_sel never matches any generated channel index.
    assign hit = load && (ch_sel == SEL_W'(i));

    // cnt > act is treated as terminal so a stray value can never run away.
    assign term = (cnt >= act);

    // Only the 1->0 terminal edge ends a full period; apply shadow there.
    assign apply = en[i] && term && dclk && pend;

    always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
        cnt  <= '0;
        act  <= RST_HALF;
        shd  <= RST_HALF;
        pend <= 1'b0;
        dclk <= 1'b0;
        tck  <= 1'b0;
        ack  <= 1'b0;
      end else begin
        tck <= 1'b0;
        ack <= 1'b0;
        if (en[i]) begin
          if (term) begin
            cnt  <= '0;
            dclk <= ~dclk;
            tck  <= ~dclk;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
          if (apply) begin
            act <= shd;
            ack <= 1'b1;
          end
        end
        if (hit) begin
          shd  <= div_val;
          pend <= 1'b1;
        end else if (apply) begin
          pend <= 1'b0;
        end
      end
    end

    assign divided_clk[i] = dclk;
    assign tick[i]        = tck;
    assign load_ack[i]    = ack;
    assign pending[i]     = pend;
  end

endmodule

// File: doc/clk_divider_prog.md
CLK_DIVIDER_PROG -- requirements
Module: clk_divider_prog

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, giving the number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 24, giving the counter and half-period value width.
REQ-003 SHALL have parameter SEL_W, default 1, giving the channel-select width (2**SEL_W >= NUM_CH).
REQ-004 SHALL have parameter RST_HALF, default 24'd10_000_000, giving the half-period value every channel loads at reset.
REQ-005 SHALL have port clk_in, input, 1 bit: clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port en, input, NUM_CH bits: per-channel count enable.
REQ-008 SHALL have port load, input, 1 bit: request to write div_val into the shadow register of channel ch_sel.
REQ-009 SHALL have port ch_sel, input, SEL_W bits: target channel for load.
REQ-010 SHALL have port div_val, input, CNT_W bits: new half-period value H.
REQ-011 SHALL have port divided_clk, output reg, NUM_CH bits: divided clock per channel.
REQ-012 SHALL have port tick, output reg, NUM_CH bits: one-cycle pulse per channel coincident with the divided_clk 0->1 transition.
REQ-013 SHALL have port load_ack, output reg, NUM_CH bits: one-cycle pulse when a pending value becomes active.
REQ-014 SHALL have port pending, output, NUM_CH bits: shadow value waiting to be applied.

Function
REQ-015 SHALL keep, per channel: counter cnt[CNT_W], active half-period act[CNT_W], shadow shd[CNT_W], pending flag.
REQ-016 SHALL, with en[i]=1 and cnt!=act, increment cnt by 1 each cycle and hold divided_clk[i].
REQ-017 SHALL, with en[i]=1 and cnt==act (terminal), clear cnt to 0 and invert divided_clk[i] on the same edge.
REQ-018 SHALL make the divided_clk period 2*(H+1) clk_in cycles with 50% duty; H=0 gives clk_in/2.
REQ-019 SHALL assert tick[i] for exactly the cycle where divided_clk[i] becomes 1, and hold it 0 otherwise.
REQ-020 SHALL, with en[i]=0, freeze cnt and divided_clk[i], force tick[i]=0, and neither apply pending values nor pulse load_ack.
REQ-021 SHALL, on load=1, write div_val into shd of channel ch_sel and set its pending flag on the next edge; ignore the load if ch_sel>=NUM_CH.
REQ-022 SHALL apply a pending value only at a terminal event where divided_clk goes 1->0 (end of a full period), so no runt pulses occur.
REQ-023 SHALL, at the applying edge: act<=shd, clear pending, pulse load_ack[i] for one cycle; cnt restarts at 0.
REQ-024 SHALL let a second load before application overwrite shd, keep pending=1, and produce only one load_ack.
REQ-025 SHALL, when load to channel i coincides with its applying edge, apply the old shd, then keep the new value pending (pending stays 1).
REQ-026 SHALL, when the current cnt exceeds a newly applied act (impossible by REQ-023), be safe by design; cnt>act from any cause SHALL be treated as terminal.
REQ-027 SHALL operate channels fully independently; a load to one channel SHALL NOT affect the cnt, act or outputs of another.
REQ-028 SHALL count modulo 2**CNT_W without width extension; div_val is taken unsigned.

Reset
REQ-029 SHALL, while rst=1, asynchronously force: cnt=0, act=RST_HALF, shd=RST_HALF, pending=0, divided_clk=0, tick=0, load_ack=0.
REQ-030 SHALL discard any pending value on reset assertion mid-operation; the first rising edge after release SHALL begin counting from 0.

Verification
REQ-031 SHALL cover: NUM_CH=2, CNT_W=8, RST_HALF=3, en=2'b11 -> both divided_clk toggle every 4 cycles (period 8); tick is high once per 8 cycles.
REQ-032 SHALL cover: load ch 0, div_val=1, mid-high-phase -> old period completes, load_ack[0] pulses at the 1->0 edge, then period 4; ch 1 is unchanged.
REQ-033 SHALL cover: two loads to ch 1 (5 then 0) before the boundary -> single load_ack[1], then period 2 (clk_in/2).
REQ-034 SHALL cover: en[0]=0 for 10 cycles mid-count -> cnt and divided_clk[0] frozen, tick[0]=0, pending load not applied until en resumes and the boundary occurs.
REQ-035 SHALL cover: rst pulse with pending=1 and divided_clk=1 -> all outputs 0 immediately (asynchronously), pending=0, act back to 3.
REQ-036 SHALL cover: load with ch_sel=3 while NUM_CH=2 -> no state change and no load_ack.
